// File: rtl/wbm_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : wbm_arbiter2
// Purpose  : Two-master round-robin Wishbone arbiter with an outstanding
//            request limit and an ack timeout that forcibly ends a tenure.
// Revision : 1.0
// ============================================================================
module wbm_arbiter2 #(
  parameter int TIMEOUT = 64,
  parameter int MAX_OUT = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  output logic        o_m0_ack,
  output logic        o_m0_stall,
  output logic        o_m0_err,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  output logic        o_m1_ack,
  output logic        o_m1_stall,
  output logic        o_m1_err,
  output logic [31:0] o_m1_data,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  input  logic        i_s_ack,
  input  logic        i_s_stall,
  input  logic [31:0] i_s_data
);

  localparam int                 c_tmo_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_lim = c_tmo_w'(TIMEOUT);
  localparam logic [2:0]         c_max_out = 3'(MAX_OUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last;   // 1 when master 1 was served last
  logic [2:0]         r_out;
  logic [c_tmo_w-1:0] r_tmo;

  logic w_gnt0, w_gnt1, w_gnt, w_full, w_tmo_hit, w_ack_ok, w_acc;

  // Grants are masked by reset so nothing leaks out while reset is held.
  assign w_gnt0    = (r_state == GNT0) && !i_rst;
  assign w_gnt1    = (r_state == GNT1) && !i_rst;
  assign w_gnt     = w_gnt0 || w_gnt1;
  assign w_full    = (r_out == c_max_out);
  assign w_tmo_hit = w_gnt && (r_tmo == c_tmo_lim);
  // An ack with nothing outstanding is stale (aborted tenure) and is dropped.
  assign w_ack_ok  = w_gnt && i_s_ack && (r_out != 3'd0);
  assign w_acc     = o_s_stb && !i_s_stall;

  assign o_m0_data = i_s_data;
  assign o_m1_data = i_s_data;

  always_comb begin
    w_next     = r_state;
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_m0_stall = 1'b1;
    o_m1_stall = 1'b1;
    o_m0_ack   = 1'b0;
    o_m1_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m1_err   = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) w_next = r_last ? GNT0 : GNT1;
        else if (i_m0_cyc)        w_next = GNT0;
        else if (i_m1_cyc)        w_next = GNT1;
      end
      GNT0:    if (!i_m0_cyc || w_tmo_hit) w_next = IDLE;
      GNT1:    if (!i_m1_cyc || w_tmo_hit) w_next = IDLE;
      default: w_next = IDLE;
    endcase

    if (w_gnt0) begin
      o_s_cyc    = i_m0_cyc;
      o_s_stb    = i_m0_stb && !w_full;
      o_s_we     = i_m0_we;
      o_s_addr   = i_m0_addr;
      o_s_data   = i_m0_data;
      o_m0_stall = w_full || i_s_stall;
      o_m0_ack   = w_ack_ok;
      o_m0_err   = w_tmo_hit;
    end else if (w_gnt1) begin
      o_s_cyc    = i_m1_cyc;
      o_s_stb    = i_m1_stb && !w_full;
      o_s_we     = i_m1_we;
      o_s_addr   = i_m1_addr;
      o_s_data   = i_m1_data;
      o_m1_stall = w_full || i_s_stall;
      o_m1_ack   = w_ack_ok;
      o_m1_err   = w_tmo_hit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_out   <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == GNT0) r_last <= 1'b0;
      if (r_state == IDLE && w_next == GNT1) r_last <= 1'b1;

      if (!w_gnt || (w_next != r_state)) begin
        r_out <= '0;
        r_tmo <= '0;
      end else begin
        if (w_acc && !w_ack_ok)      r_out <= r_out + 3'd1;
        else if (!w_acc && w_ack_ok) r_out <= r_out - 3'd1;

        if (i_s_ack)                          r_tmo <= '0;
        else if (r_out != 3'd0 && !w_tmo_hit) r_tmo <= r_tmo + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wbm_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbm_arbiter2
// Purpose  : Directed scenarios plus randomized traffic against a
//            transaction-level model of the two-master arbiter.
// Revision : 1.0
// ============================================================================
module tb_wbm_arbiter2;

  localparam int TIMEOUT = 64;
  localparam int MAX_OUT = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_addr = '0, m0_data = '0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_addr = '0, m1_data = '0;
  logic        s_ack = 0, s_stall = 0;
  logic [31:0] s_data = '0;
  logic        o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err;
  logic [31:0] o_m0_data, o_m1_data;
  logic        o_s_cyc, o_s_stb, o_s_we;
  logic [31:0] o_s_addr, o_s_data;

  int checks = 0;
  int errors = 0;

  wbm_arbiter2 #(.TIMEOUT(TIMEOUT), .MAX_OUT(MAX_OUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we),
    .i_m0_addr(m0_addr), .i_m0_data(m0_data),
    .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err),
    .o_m0_data(o_m0_data),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we),
    .i_m1_addr(m1_addr), .i_m1_data(m1_data),
    .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err),
    .o_m1_data(o_m1_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data),
    .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_data)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, who was served last, how many
  // requests are in flight and how long we have waited for an ack.
  int m_gnt  = -1;
  int m_last = 1;
  int m_out  = 0;
  int m_tmo  = 0;

  always @(posedge clk) begin : model
    bit mcyc, acc, ackd;
    int prev;
    if (rst) begin
      m_gnt = -1; m_last = 1; m_out = 0; m_tmo = 0;
    end else if (m_gnt < 0) begin
      if (m0_cyc && m1_cyc) m_gnt = (m_last == 0) ? 1 : 0;
      else if (m0_cyc)      m_gnt = 0;
      else if (m1_cyc)      m_gnt = 1;
      if (m_gnt >= 0) m_last = m_gnt;
      m_out = 0; m_tmo = 0;
    end else begin
      mcyc = (m_gnt == 0) ? m0_cyc : m1_cyc;
      if (!mcyc || m_tmo == TIMEOUT) begin
        m_gnt = -1; m_out = 0; m_tmo = 0;
      end else begin
        prev  = m_out;
        acc   = ((m_gnt == 0) ? m0_stb : m1_stb) && (prev < MAX_OUT) && !s_stall;
        ackd  = s_ack && (prev > 0);
        m_out = prev + (acc ? 1 : 0) - (ackd ? 1 : 0);
        if (s_ack)         m_tmo = 0;
        else if (prev > 0) m_tmo = m_tmo + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1; s_ack = 1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({o_s_cyc, o_s_stb, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_m0_stall, o_m1_stall} !== 8'b0000_0011) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=00000011",
               {o_s_cyc, o_s_stb, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_m0_stall, o_m1_stall});
    end
    tick();
    rst = 0; m0_cyc = 0; m1_cyc = 0; m0_stb = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk);
    checks++;
    if ({o_s_cyc, o_s_stb, o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall, o_s_addr} !== {6'b000011, 32'h0}) begin
      errors++;
      $display("FAIL reset_after got=%b addr=%h exp=000011 addr=0",
               {o_s_cyc, o_s_stb, o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall}, o_s_addr);
    end
    tick();
  endtask

  task automatic test_tie();
    m0_cyc = 1; m1_cyc = 1; m0_addr = 32'h1111_0000; m1_addr = 32'h2222_0000;
    @(negedge clk);
    checks++;
    if (o_s_cyc !== 1'b0) begin errors++; $display("FAIL tie_idle o_s_cyc=%b exp=0", o_s_cyc); end
    tick();
    @(negedge clk);
    checks++;
    if ({o_s_cyc, o_m0_stall, o_m1_stall, o_s_addr} !== {3'b101, 32'h1111_0000}) begin
      errors++;
      $display("FAIL tie_gnt0 cyc/st0/st1=%b addr=%h exp=101 addr=11110000",
               {o_s_cyc, o_m0_stall, o_m1_stall}, o_s_addr);
    end
    tick();
    m0_cyc = 0;
    tick();
    @(negedge clk);
    checks++;
    if ({o_s_cyc, o_m1_stall} !== 2'b01) begin
      errors++; $display("FAIL tie_idle_gap cyc/st1=%b exp=01", {o_s_cyc, o_m1_stall});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({o_s_cyc, o_m0_stall, o_m1_stall, o_s_addr} !== {3'b110, 32'h2222_0000}) begin
      errors++;
      $display("FAIL tie_gnt1 cyc/st0/st1=%b addr=%h exp=110 addr=22220000",
               {o_s_cyc, o_m0_stall, o_m1_stall}, o_s_addr);
    end
    tick();
    m1_cyc = 0;
    tick(); tick();
  endtask

  task automatic test_write();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h2000_000C; m0_data = 32'h41;
    tick();
    @(negedge clk);
    checks++;
    if ({o_s_stb, o_s_we, o_s_addr, o_s_data} !== {2'b11, 32'h2000_000C, 32'h41}) begin
      errors++;
      $display("FAIL write_req stb/we=%b addr=%h data=%h exp=11 2000000c 00000041",
               {o_s_stb, o_s_we}, o_s_addr, o_s_data);
    end
    tick();
    m0_stb = 0; s_ack = 1;
    @(negedge clk);
    checks++;
    if ({o_m0_ack, o_m1_ack} !== 2'b10) begin
      errors++; $display("FAIL write_ack m0/m1=%b exp=10", {o_m0_ack, o_m1_ack});
    end
    tick();
    s_ack = 0;
    @(negedge clk);
    checks++;
    if (o_m0_ack !== 1'b0) begin errors++; $display("FAIL write_ack_len o_m0_ack=%b exp=0", o_m0_ack); end
    m0_cyc = 0; m0_we = 0;
    tick(); tick();
  endtask

  task automatic test_read();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h2000_0004;
    tick();
    @(negedge clk);
    checks++;
    if ({o_s_stb, o_s_we, o_s_addr} !== {2'b10, 32'h2000_0004}) begin
      errors++;
      $display("FAIL read_req stb/we=%b addr=%h exp=10 20000004", {o_s_stb, o_s_we}, o_s_addr);
    end
    tick();
    m1_stb = 0; s_ack = 1; s_data = 32'h0000_000A;
    @(negedge clk);
    checks++;
    if ({o_m1_ack, o_m0_ack, o_m1_data} !== {2'b10, 32'h0000_000A}) begin
      errors++;
      $display("FAIL read_ack m1/m0=%b data=%h exp=10 0000000a", {o_m1_ack, o_m0_ack}, o_m1_data);
    end
    tick();
    s_ack = 0; m1_cyc = 0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int first_err, n_err;
    first_err = -1; n_err = 0;
    m0_cyc = 1; m0_stb = 1;
    tick();
    tick();
    m0_stb = 0;
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      if (o_m0_err === 1'b1) begin
        n_err++;
        if (first_err < 0) first_err = i;
      end
      if (i == 66) begin
        checks++;
        if (o_s_cyc !== 1'b0) begin errors++; $display("FAIL timeout_idle o_s_cyc=%b exp=0", o_s_cyc); end
      end
      tick();
    end
    checks++;
    if (first_err != 65 || n_err != 1) begin
      errors++;
      $display("FAIL timeout_err first_cycle=%0d pulses=%0d exp first_cycle=65 pulses=1", first_err, n_err);
    end
    @(negedge clk);
    checks++;
    if ({o_s_cyc, o_m0_stall} !== 2'b10) begin
      errors++; $display("FAIL timeout_regrant cyc/st0=%b exp=10", {o_s_cyc, o_m0_stall});
    end
    m0_cyc = 0;
    tick(); tick();
  endtask

  task automatic test_max_out();
    int bad;
    bad = 0;
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if ({o_s_stb, o_m0_stall} !== 2'b10) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL maxout_fill bad_cycles=%0d exp=0", bad); end
    @(negedge clk);
    checks++;
    if ({o_s_stb, o_m0_stall} !== 2'b01) begin
      errors++; $display("FAIL maxout_8th stb/st0=%b exp=01", {o_s_stb, o_m0_stall});
    end
    tick();
    s_ack = 1;
    @(negedge clk);
    checks++;
    if ({o_m0_ack, o_m0_stall} !== 2'b11) begin
      errors++; $display("FAIL maxout_ack ack/st0=%b exp=11", {o_m0_ack, o_m0_stall});
    end
    tick();
    s_ack = 0;
    @(negedge clk);
    checks++;
    if ({o_s_stb, o_m0_stall} !== 2'b10) begin
      errors++; $display("FAIL maxout_release stb/st0=%b exp=10", {o_s_stb, o_m0_stall});
    end
    m0_cyc = 0; m0_stb = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    m1_cyc = 1; m1_stb = 1;
    tick();
    tick();
    m1_stb = 0; rst = 1;
    @(negedge clk);
    checks++;
    if ({o_s_cyc, o_m1_stall} !== 2'b01) begin
      errors++; $display("FAIL rstmid_during cyc/st1=%b exp=01", {o_s_cyc, o_m1_stall});
    end
    tick();
    rst = 0; s_ack = 1;
    @(negedge clk);
    checks++;
    if ({o_m1_ack, o_m1_err, o_s_cyc} !== 3'b000) begin
      errors++; $display("FAIL rstmid_late_ack ack/err/cyc=%b exp=000", {o_m1_ack, o_m1_err, o_s_cyc});
    end
    tick();
    s_ack = 0; m1_cyc = 0;
    tick(); tick();
  endtask

  task automatic test_random();
    int g;
    logic [66:0] exp_s;
    logic [69:0] exp_m;
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(299) == 0);
      if ($urandom_range(15) == 0) m0_cyc = !m0_cyc;
      if ($urandom_range(15) == 0) m1_cyc = !m1_cyc;
      m0_stb  = $urandom_range(1); m1_stb = $urandom_range(1);
      m0_we   = $urandom_range(1); m1_we  = $urandom_range(1);
      m0_addr = $urandom; m0_data = $urandom; m1_addr = $urandom; m1_data = $urandom;
      s_stall = ($urandom_range(3) == 0);
      s_ack   = ((n % 400) < 300) && ($urandom_range(4) < 2);
      s_data  = $urandom;
      @(negedge clk);
      g = rst ? -1 : m_gnt;
      if (g == 0)
        exp_s = {m0_cyc, m0_stb && (m_out < MAX_OUT), m0_we, m0_addr, m0_data};
      else if (g == 1)
        exp_s = {m1_cyc, m1_stb && (m_out < MAX_OUT), m1_we, m1_addr, m1_data};
      else
        exp_s = '0;
      exp_m = {(g != 0) || (m_out == MAX_OUT) || s_stall, (g == 0) && s_ack && (m_out > 0),
               (g == 0) && (m_tmo == TIMEOUT),
               (g != 1) || (m_out == MAX_OUT) || s_stall, (g == 1) && s_ack && (m_out > 0),
               (g == 1) && (m_tmo == TIMEOUT), s_data, s_data};
      checks++;
      if ({o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data} !== exp_s) begin
        errors++;
        $display("FAIL rand_slave n=%0d got=%h exp=%h", n,
                 {o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data}, exp_s);
      end
      checks++;
      if ({o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err, o_m0_data, o_m1_data} !== exp_m) begin
        errors++;
        $display("FAIL rand_master n=%0d got=%h exp=%h", n,
                 {o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err, o_m0_data, o_m1_data}, exp_m);
      end
      tick();
    end
    rst = 0; m0_cyc = 0; m1_cyc = 0; s_ack = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write();
    test_read();
    test_timeout();
    test_max_out();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
